pkt_mod_load: RTL and testbench
===============================

Name: pkt_mod_load

Overview:
DDR-to-stream packet reader; the read-side counterpart of pkt_mod_store.
- Accepts one packet descriptor (DDR byte address, byte length) at a time.
- Fetches the packet from DDR over AXI4 read (AR/R) as INCR bursts.
- Emits it as an AXI-Stream packet with tlast and tkeep.
- Sits between the packet buffer in DDR and the egress stream path.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 512, AXI/stream data width (BEAT_BYTES = DATA_WIDTH/8 = 64)
ID_WIDTH, 4, AXI ID width
AXI_ID, 0, constant driven on m_axi_arid
MAX_BURST_BEATS, 16, maximum beats per AR burst (1..256)

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  synchronous active-high reset
desc_addr  in  ADDR_WIDTH  packet start address, beat-aligned (low log2(BEAT_BYTES) bits ignored, treated as 0)
desc_len  in  16  packet length in bytes
desc_valid  in  1  descriptor valid
desc_ready  out  1  descriptor accepted when valid&ready
m_axi_arid  out  ID_WIDTH  = AXI_ID
m_axi_araddr  out  ADDR_WIDTH  burst start address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  log2(BEAT_BYTES), constant
m_axi_arburst  out  2  2'b01 INCR, constant
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address ready
m_axi_rid  in  ID_WIDTH  read ID (ignored)
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tkeep  out  DATA_WIDTH/8  byte enables
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  last beat of packet
pkt_done  out  1  one-cycle pulse when the tlast beat is accepted
rd_err  out  1  sticky error flag

Behaviour:
- Reset: state IDLE; desc_ready=1, m_axi_arvalid=0, pkt_done=0, rd_err=0.
- m_axi_rready and m_axis_tvalid are 0 outside DATA. Constant outputs hold their values.
- FSM states: IDLE, AR, DATA.
- IDLE:
  - desc_ready=1.
  - On handshake: latch addr, total_beats = ceil(desc_len/64), last_keep.
  - last_keep = all ones if desc_len%64==0, else low (desc_len%64) bits set.
  - desc_len==0: descriptor consumed, no AXI traffic, no pulse, stay IDLE.
  - Otherwise go to AR next cycle.
- AR:
  - arvalid=1 with araddr=cur_addr.
  - burst = min(remaining_beats, MAX_BURST_BEATS, (4096 - cur_addr[11:0])/64). Bursts never cross a 4 KB boundary.
  - arlen = burst-1.
  - Address and length stay stable while arvalid=1 and arready=0.
  - On arready: cur_addr += burst*64, remaining -= burst, beat_cnt = burst; go to DATA.
- DATA:
  - m_axis_tdata = rdata, m_axis_tvalid = rvalid, m_axi_rready = m_axis_tready. This is a combinational pass-through with zero added latency; no beat is dropped or duplicated under backpressure.
  - tlast = 1 on the final beat of the final burst. tkeep = last_keep on that beat, all ones otherwise.
  - On each accepted beat, beat_cnt decrements.
  - On the accepted beat with beat_cnt==1: if remaining>0 go to AR, else pkt_done pulses 1 cycle and go to IDLE.
- Exactly one burst outstanding at a time; the next AR is issued only after the previous burst's last beat is accepted.
- rd_err is set, and stays set until rst, when either:
  - an accepted beat has rresp != 2'b00; or
  - rlast disagrees with beat_cnt==1.
  Data is still forwarded, and burst termination follows beat_cnt, not rlast.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Reset mid-operation: the FSM returns to IDLE immediately and all counters clear. The bench resets the AXI slave simultaneously.

Test Plan:
- Desc (0x1000, 400), always-ready slave/sink -> one AR: araddr 0x1000, arlen 6; 7 stream beats; last beat tkeep 0x0000_0000_0000_FFFF, tlast=1; pkt_done one pulse.
- Desc (0x2000, 2048), MAX_BURST_BEATS=16 -> two ARs: 0x2000/arlen 15, then 0x2400/arlen 15; 32 beats, tlast only on beat 32, tkeep all ones.
- Desc (0x0FC0, 128) -> 4 KB split: AR 0x0FC0/arlen 0, then AR 0x1000/arlen 0; 2 beats, tlast on the second.
- Desc (0x3000, 800) with m_axis_tready toggling every cycle and rvalid randomly gapped -> rready mirrors tready; 13 beats delivered in order with rdata matching; last tkeep = low 32 bits set.
- Back-to-back descriptors 6 B and 61 B -> two single-beat packets with arlen 0; tkeep 0x3F then low 61 bits set; tlast on both; two pkt_done pulses; rd_err stays 0.
- rresp=2'b10 on one beat -> rd_err=1 from the next cycle until rst. Desc len 0 -> no arvalid, desc_ready stays 1. rst asserted mid-DATA -> next cycle IDLE, arvalid=0, tvalid=0.

Source files
------------

// File: rtl/pkt_mod_load.sv
// pkt_mod_load
// ------------
// Reads one packet at a time out of DDR and replays it as an AXI-Stream
// packet.  A descriptor (start address, byte length) is split into AXI4 INCR
// read bursts.  Each burst is at most MAX_BURST_BEATS beats long and never
// crosses a 4 KB page.  The returned read beats are passed straight through to
// the stream port, and tlast/tkeep are added on the final beat.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   desc_addr/len/valid descriptor input; desc_ready is high only in IDLE
//   m_axi_ar*           AXI4 read-address channel (one burst outstanding)
//   m_axi_r*            AXI4 read-data channel (rid ignored)
//   m_axis_t*           AXI-Stream output (tdata/tkeep/tlast/tvalid/tready)
//   pkt_done            one-cycle pulse, registered, after the tlast beat is taken
//   rd_err              sticky: bad rresp or rlast out of step with the beat count
//   fsm_state           current FSM state, for debug and checkers
//
// Handshake rule for every channel: a transfer happens on a rising edge where
// valid and ready are both high.  A source holds its payload stable while
// valid is high and ready is low.  A sink may change ready freely.
module pkt_mod_load #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 4,
    parameter int AXI_ID          = 0,
    parameter int MAX_BURST_BEATS = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   desc_addr,
    input  logic [15:0]             desc_len,
    input  logic                    desc_valid,
    output logic                    desc_ready,

    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,

    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,

    output logic                    pkt_done,
    output logic                    rd_err,
    output logic [1:0]              fsm_state
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(BEAT_BYTES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AR   = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [15:0]           remaining;   // beats not yet requested on AR
    logic [8:0]            beat_cnt;    // beats left in the current burst
    logic [BEAT_BYTES-1:0] last_keep;

    // The low offset bits of desc_addr and the read ID are ignored on purpose.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_rid, desc_addr[OFF_W-1:0]};

    // Descriptor decode: beat count rounded up, and the tkeep for the tail beat.
    logic [16:0]           len_round;
    logic [15:0]           desc_beats;
    logic [OFF_W-1:0]      len_tail;
    logic [BEAT_BYTES-1:0] desc_keep;

    assign len_round  = {1'b0, desc_len} + 17'(BEAT_BYTES - 1);
    assign desc_beats = 16'(len_round >> OFF_W);
    assign len_tail   = desc_len[OFF_W-1:0];
    assign desc_keep  = (len_tail == '0) ? '1 : ~({BEAT_BYTES{1'b1}} << len_tail);

    // Burst sizing.  The burst is limited by the beats still to fetch, by the
    // maximum burst length, and by the beats left before the next 4 KB page.
    // cur_addr and remaining do not change in AR, so araddr and arlen stay
    // stable while the request waits for arready.
    logic [12:0]           page_bytes;
    logic [15:0]           page_beats;
    logic [15:0]           burst;
    logic [ADDR_WIDTH-1:0] burst_bytes;

    assign page_bytes = 13'h1000 - {1'b0, cur_addr[11:0]};
    assign page_beats = 16'(page_bytes >> OFF_W);

    always_comb begin
        burst = remaining;
        if (burst > 16'(MAX_BURST_BEATS)) burst = 16'(MAX_BURST_BEATS);
        if (burst > page_beats)           burst = page_beats;
    end

    assign burst_bytes = ADDR_WIDTH'(burst) << OFF_W;

    // Read channel outputs.  The fixed fields are tied off here.
    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_arsize  = 3'(OFF_W);
    assign m_axi_arburst = 2'b01;
    assign m_axi_araddr  = cur_addr;
    assign m_axi_arlen   = 8'(burst - 16'd1);
    assign m_axi_arvalid = (state == ST_AR);
    assign desc_ready    = (state == ST_IDLE);
    assign fsm_state     = state;

    // Zero-latency pass-through in DATA.  The stream sink's ready becomes
    // rready, so a beat is taken from R exactly when it is taken by the sink.
    logic in_data;
    logic beat_fire;
    logic final_beat;

    assign in_data       = (state == ST_DATA);
    assign beat_fire     = in_data && m_axi_rvalid && m_axis_tready;
    assign final_beat    = (beat_cnt == 9'd1);
    assign m_axi_rready  = in_data && m_axis_tready;
    assign m_axis_tvalid = in_data && m_axi_rvalid;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = in_data && final_beat && (remaining == 16'd0);
    assign m_axis_tkeep  = m_axis_tlast ? last_keep : '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            last_keep <= '0;
            pkt_done  <= 1'b0;
            rd_err    <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (desc_valid) begin
                        cur_addr  <= {desc_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        remaining <= desc_beats;
                        last_keep <= desc_keep;
                        // A zero-length descriptor is consumed with no AXI traffic.
                        if (desc_len != 16'd0) state <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (m_axi_arready) begin
                        cur_addr  <= cur_addr + burst_bytes;
                        remaining <= remaining - burst;
                        beat_cnt  <= 9'(burst);
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt - 9'd1;
                        // The burst ends on our own beat count.  An rlast that
                        // disagrees with it is only reported as an error.
                        if ((m_axi_rresp != 2'b00) || (m_axi_rlast != final_beat))
                            rd_err <= 1'b1;
                        if (final_beat) begin
                            if (remaining != 16'd0) begin
                                state <= ST_AR;
                            end else begin
                                state    <= ST_IDLE;
                                pkt_done <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_mod_load.sv
// Testbench for pkt_mod_load.  A small AXI read slave serves a synthetic
// memory image.  A behavioural model expands every accepted descriptor into
// the AR requests and stream beats that must appear.
`timescale 1ns/1ps
module tb_pkt_mod_load;
  localparam int AW   = 32;
  localparam int DW   = 512;
  localparam int IW   = 4;
  localparam int KW   = DW / 8;
  localparam int MAXB = 16;

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; } beat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] desc_addr;
  logic [15:0]   desc_len;
  logic          desc_valid, desc_ready;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid, m_axi_arready;
  logic [IW-1:0] m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic          pkt_done, rd_err;
  logic [1:0]    fsm_state;

  pkt_mod_load #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(0), .MAX_BURST_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst),
    .desc_addr(desc_addr), .desc_len(desc_len), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .pkt_done(pkt_done), .rd_err(rd_err), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  ar_t   exp_ar_q[$];
  beat_t exp_beat_q[$];
  int pkts_exp = 0;
  int done_cnt = 0;
  int t_cnt    = 0;
  bit done_exp = 0;
  bit err_model = 0;

  // environment knobs
  int tready_mode = 0;   // 0 always ready, 1 toggle, 2 random
  int rgap_pct    = 0;   // percent of cycles with an rvalid gap
  bit ar_rand     = 0;
  bit inject_err  = 0;

  // slave state
  ar_t s_q[$];
  ar_t s_cur;
  int  s_idx = 0;
  bit  s_busy = 0;
  bit  last_r_hs = 0;
  bit  prev_ar_wait = 0;
  logic [AW-1:0] prev_araddr;
  logic [7:0]    prev_arlen;
  bit  tog = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int j = 0; j < DW / 32; j++)
      w[j*32 +: 32] = (a * 32'h9E37_79B1) ^ (32'(j) << 24) ^ a;
    return w;
  endfunction

  // Behavioural expansion of one descriptor into AR requests and stream beats.
  task automatic model_desc(input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] a;
    int beats, left, idx, page, b, tail;
    ar_t ar;
    beat_t bt;
    if (len == 0) return;
    a = addr & 32'hFFFF_FFC0;
    beats = (len + 63) / 64;
    left = beats;
    idx = 0;
    while (left > 0) begin
      page = (4096 - int'(a % 4096)) / 64;
      b = left;
      if (b > MAXB) b = MAXB;
      if (b > page) b = page;
      ar.addr = a;
      ar.len = 8'(b - 1);
      exp_ar_q.push_back(ar);
      for (int k = 0; k < b; k++) begin
        idx++;
        bt.data = mem_word(a + 32'(k * 64));
        bt.last = (idx == beats);
        bt.keep = '1;
        if (bt.last) begin
          tail = len - (beats - 1) * 64;
          for (int i = 0; i < KW; i++) bt.keep[i] = (i < tail);
        end
        exp_beat_q.push_back(bt);
      end
      a = a + 32'(b * 64);
      left -= b;
    end
    pkts_exp++;
  endtask

  // Per-cycle sampling at posedge-1: the handshakes seen here complete at the next edge.
  task automatic sample_cycle();
    bit ar_hs, r_hs, t_hs;
    ar_t a, sa;
    beat_t b;
    if (rst) begin
      exp_ar_q.delete();
      exp_beat_q.delete();
      s_q.delete();
      err_model = 0;
      done_exp = 0;
      last_r_hs = 0;
      prev_ar_wait = 0;
      return;
    end
    ar_hs = m_axi_arvalid && m_axi_arready;
    r_hs  = m_axi_rvalid && m_axi_rready;
    t_hs  = m_axis_tvalid && m_axis_tready;
    chk("pkt_done", {511'd0, pkt_done}, {511'd0, done_exp});
    chk("rd_err", {511'd0, rd_err}, {511'd0, err_model});
    if (prev_ar_wait) begin
      chk("ar_hold_valid", {511'd0, m_axi_arvalid}, 1);
      chk("ar_hold_addr", m_axi_araddr, prev_araddr);
      chk("ar_hold_len", m_axi_arlen, prev_arlen);
    end
    if (m_axi_arvalid) begin
      chk("arid", m_axi_arid, 0);
      chk("arsize", m_axi_arsize, 6);
      chk("arburst", m_axi_arburst, 1);
    end
    if (ar_hs) begin
      if (exp_ar_q.size() == 0) fail_msg("ar_unexpected");
      else begin
        a = exp_ar_q.pop_front();
        chk("araddr", m_axi_araddr, a.addr);
        chk("arlen", m_axi_arlen, a.len);
      end
      sa.addr = m_axi_araddr;
      sa.len  = m_axi_arlen;
      s_q.push_back(sa);
    end
    if (m_axi_rvalid) begin
      chk("tvalid_pass", {511'd0, m_axis_tvalid}, 1);
      chk("rready_pass", {511'd0, m_axi_rready}, {511'd0, m_axis_tready});
      chk("tdata_pass", m_axis_tdata, m_axi_rdata);
    end else begin
      chk("tvalid_idle", {511'd0, m_axis_tvalid}, 0);
    end
    done_exp = 0;
    if (t_hs) begin
      t_cnt++;
      if (exp_beat_q.size() == 0) fail_msg("beat_unexpected");
      else begin
        b = exp_beat_q.pop_front();
        chk("tdata", m_axis_tdata, b.data);
        chk("tkeep", m_axis_tkeep, b.keep);
        chk("tlast", {511'd0, m_axis_tlast}, {511'd0, b.last});
        done_exp = b.last;
      end
    end
    if (r_hs && m_axi_rresp != 2'b00) err_model = 1;
    if (pkt_done) done_cnt++;
    prev_ar_wait = m_axi_arvalid && !m_axi_arready;
    prev_araddr = m_axi_araddr;
    prev_arlen = m_axi_arlen;
    last_r_hs = r_hs;
  endtask

  // ---------------- driver: AXI slave + stream sink ----------------
  initial begin
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0;
    m_axi_rlast = 0; m_axi_rid = '0; m_axis_tready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_q.delete();
        s_busy = 0;
        s_idx = 0;
        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
        m_axi_arready = 0; m_axis_tready = 0;
      end else begin
        if (last_r_hs) begin
          s_idx++;
          if (s_idx > int'(s_cur.len)) s_busy = 0;
        end
        if (!s_busy && s_q.size() > 0) begin
          s_cur = s_q.pop_front();
          s_busy = 1;
          s_idx = 0;
        end
        if (!(m_axi_rvalid && !last_r_hs)) begin
          if (s_busy && int'($urandom_range(0, 99)) >= rgap_pct) begin
            m_axi_rvalid = 1;
            m_axi_rdata  = mem_word(s_cur.addr + 32'(s_idx * 64));
            m_axi_rlast  = (s_idx == int'(s_cur.len));
            m_axi_rresp  = inject_err ? 2'b10 : 2'b00;
            inject_err   = 0;
          end else begin
            m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
          end
        end
        m_axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        tog = ~tog;
        case (tready_mode)
          0: m_axis_tready = 1'b1;
          1: m_axis_tready = tog;
          default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
      end
      #4;
      sample_cycle();
    end
  end

  // ---------------- descriptor driver ----------------
  task automatic send_desc(input logic [AW-1:0] a, input int len);
    int n = 0;
    @(negedge clk); #1;
    desc_addr = a; desc_len = 16'(len); desc_valid = 1;
    #2;
    while (!desc_ready && n < 3000) begin
      @(negedge clk); #3;
      n++;
    end
    if (!desc_ready) fail_msg("desc_timeout");
    else model_desc(a, len);
    @(negedge clk); #1;
    desc_valid = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    do begin
      @(negedge clk); #3;
      n++;
    end while ((exp_ar_q.size() != 0 || exp_beat_q.size() != 0 || !desc_ready) && n < 5000);
    if (n >= 5000) fail_msg({nm, "_timeout"});
    repeat (2) @(negedge clk);
    #3;
    chk({nm, "_pkts"}, done_cnt, pkts_exp);
  endtask

  task automatic set_env(input int tm, input int gap, input bit arr);
    tready_mode = tm; rgap_pct = gap; ar_rand = arr;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int start, n, len;
    logic [AW-1:0] a;
    desc_valid = 0; desc_addr = '0; desc_len = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    #1 rst = 0;
    #2;
    chk("rst_desc_ready", {511'd0, desc_ready}, 1);
    chk("rst_arvalid", {511'd0, m_axi_arvalid}, 0);
    chk("rst_pkt_done", {511'd0, pkt_done}, 0);
    chk("rst_rd_err", {511'd0, rd_err}, 0);
    chk("rst_tvalid", {511'd0, m_axis_tvalid}, 0);
    chk("rst_rready", {511'd0, m_axi_rready}, 0);

    // 1: single burst, partial tail
    set_env(0, 0, 0);
    send_desc(32'h1000, 400);
    chk("t1_nar", exp_ar_q.size(), 1);
    chk("t1_araddr", exp_ar_q[0].addr, 32'h1000);
    chk("t1_arlen", exp_ar_q[0].len, 6);
    chk("t1_nbeats", exp_beat_q.size(), 7);
    chk("t1_keep", exp_beat_q[6].keep, 64'h0000_0000_0000_FFFF);
    wait_done("t1");

    // 2: two max-length bursts
    send_desc(32'h2000, 2048);
    chk("t2_nar", exp_ar_q.size(), 2);
    chk("t2_araddr1", exp_ar_q[1].addr, 32'h2400);
    chk("t2_arlen1", exp_ar_q[1].len, 15);
    chk("t2_nbeats", exp_beat_q.size(), 32);
    wait_done("t2");

    // 3: 4 KB page split
    send_desc(32'h0FC0, 128);
    chk("t3_ar0", {exp_ar_q[0].addr, exp_ar_q[0].len}, {32'h0FC0, 8'd0});
    chk("t3_ar1", {exp_ar_q[1].addr, exp_ar_q[1].len}, {32'h1000, 8'd0});
    wait_done("t3");

    // 4: toggling tready, gapped rvalid, random arready
    set_env(1, 40, 1);
    send_desc(32'h3000, 800);
    chk("t4_nbeats", exp_beat_q.size(), 13);
    chk("t4_keep", exp_beat_q[12].keep, 64'h0000_0000_FFFF_FFFF);
    wait_done("t4");

    // 5: back-to-back single-beat packets
    set_env(0, 0, 0);
    send_desc(32'h7000, 6);
    chk("t5_keep_a", exp_beat_q[$].keep, 64'h3F);
    send_desc(32'h7040, 61);
    chk("t5_keep_b", exp_beat_q[$].keep, 64'h1FFF_FFFF_FFFF_FFFF);
    wait_done("t5");
    chk("t5_rd_err", {511'd0, rd_err}, 0);

    // 6: zero-length descriptor
    send_desc(32'h6000, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #3;
      chk("t6_arvalid", {511'd0, m_axi_arvalid}, 0);
      chk("t6_desc_ready", {511'd0, desc_ready}, 1);
    end

    // 7: error response on one beat
    inject_err = 1;
    send_desc(32'h5000, 256);
    wait_done("t7");
    chk("t7_rd_err", {511'd0, rd_err}, 1);

    // 8: randomized descriptors, including page edges and address wrap
    send_desc(32'hFFFF_FF80, 300);
    wait_done("t8_wrap");
    for (int i = 0; i < 14; i++) begin
      set_env(int'($urandom_range(0, 2)), int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)));
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[11:0] = 12'(4096 - 64 * int'($urandom_range(1, 4)));
      len = int'($urandom_range(1, 2500));
      send_desc(a, len);
      wait_done("t8_rand");
    end

    // 9: reset in the middle of DATA
    set_env(2, 30, 0);
    send_desc(32'h4000, 1024);
    start = t_cnt;
    n = 0;
    while (t_cnt < start + 3 && n < 2000) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= 2000) fail_msg("t9_no_beats");
    @(negedge clk); #1 rst = 1;
    @(negedge clk); #1 rst = 0;
    #2;
    pkts_exp--;
    chk("t9_arvalid", {511'd0, m_axi_arvalid}, 0);
    chk("t9_tvalid", {511'd0, m_axis_tvalid}, 0);
    chk("t9_desc_ready", {511'd0, desc_ready}, 1);
    chk("t9_rd_err", {511'd0, rd_err}, 0);
    set_env(0, 0, 0);
    send_desc(32'h8000, 130);
    wait_done("t9_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
